// File: rtl/vidsampler_pipe.sv
// DPI capture sampler: position counters, ordered-dither quantiser, write FIFO.
// Optional dither adder is enabled by defining VIDSAMPLER_DITHER_EN.
module vidsampler_pipe #(
    parameter int IN_BITS    = 4,
    parameter int OUT_BITS   = 2,
    parameter int STEP_LOG2  = 2,
    parameter int XBITS      = 8,
    parameter int YBITS      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   rgb_clk,
    input  logic                   rst,
    input  logic                   rgb_de,
    input  logic                   rgb_vsync,
    input  logic [IN_BITS-1:0]     rgb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [YBITS+XBITS-1:0] out_addr,
    output logic [OUT_BITS-1:0]    out_data,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [1:0]             frameno
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = YBITS + XBITS + OUT_BITS;
    localparam logic [IN_BITS:0] QMAX = (IN_BITS+1)'((1 << OUT_BITS) - 1);
    localparam logic [IN_BITS:0] ONE  = (IN_BITS+1)'(1);
    localparam logic [AW:0]      FULL = (AW+1)'(FIFO_DEPTH);

    logic [XBITS-1:0] x;
    logic [YBITS-1:0] y;
    logic [IN_BITS:0] s;
    logic [IN_BITS:0] t;
    logic [OUT_BITS-1:0] q;

`ifdef VIDSAMPLER_DITHER_EN
    logic [1:0] d;
    assign d = x[3:2] + x[1:0] + y[1:0] + frameno;
    assign s = {1'b0, rgb_data} + {{(IN_BITS-1){1'b0}}, d};
`else
    assign s = {1'b0, rgb_data};
`endif

    assign t = (s - ONE) >> STEP_LOG2;

    always_comb begin
        q = '0;
        if (s != '0) begin
            if (t > QMAX)
                q = QMAX[OUT_BITS-1:0];
            else
                q = t[OUT_BITS-1:0];
        end
    end

    // Overlong lines wrap into the next line and count as a new frame.
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            frameno <= '0;
        end else if (rgb_de) begin
            if (x != '1) begin
                x <= x + XBITS'(1);
            end else begin
                x       <= '0;
                y       <= y + YBITS'(1);
                frameno <= frameno + 2'd1;
            end
        end else if (rgb_vsync) begin
            x <= '0;
            y <= '0;
            if (y != '0)
                frameno <= frameno + 2'd1;
        end else begin
            x <= '0;
            if (x != '0)
                y <= y + YBITS'(1);
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign full      = (count == FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = rgb_de & (~full | pop);
    assign drop      = rgb_de & full & ~pop;
    assign {out_addr, out_data} = mem[rptr];

    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= {y, x, q};
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule
